// File: rtl/hash_byte_link_if.sv
// Byte stream carrying valid/ready, one data byte and an end-of-frame marker.
interface hash_byte_link_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/hash_byte_link.sv
// Byte-serial wrapper around the 6-byte -> 64-bit hashing core: gathers a 6-byte
// message, waits the core latency, then streams the 8-byte digest out MSB first.
module hash_byte_link #(
  parameter int unsigned CORE_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hash_byte_link_if.slave      s,
  hash_byte_link_if.master     m,
  output logic [47:0]          core_msg,
  input  logic [63:0]          core_digest,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     frames_done
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned MSG_BYTES = 6;
  localparam int unsigned MSG_W     = MSG_BYTES * BYTE_W;
  localparam int unsigned DIG_W     = 64;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LAT_W     = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MSG_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(7);
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(6);
  localparam logic [LAT_W-1:0] LAT_END   = LAT_W'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_SEND    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [IDX_W-1:0]  bcnt_q, bcnt_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [DIG_W-1:0]  sh_q, sh_d;
  logic [BYTE_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              m_valid_q, m_valid_d;
  logic              s_ready_q, s_ready_d;
  logic              frame_err_q, frame_err_d;
  logic [CNT_W-1:0]  frames_q, frames_d;

  logic s_hs_c;
  logic m_hs_c;
  logic lat_done_c;

  assign s_hs_c     = s.valid & s_ready_q;
  assign m_hs_c     = m_valid_q & m.ready;
  assign lat_done_c = (lat_q == LAT_END);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_COLLECT;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (s_hs_c && idx_q == LAST_IDX) state_d = s.last ? ST_WAIT : ST_DRAIN;
      ST_DRAIN:   if (s_hs_c && s.last)            state_d = ST_COLLECT;
      ST_WAIT:    if (lat_done_c)                  state_d = ST_SEND;
      ST_SEND:    if (m_hs_c && bcnt_q == LAST_BYTE) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // Next values of the registered datapath and outputs
  always_comb begin
    idx_d       = idx_q;
    lat_d       = lat_q;
    bcnt_d      = bcnt_q;
    msg_d       = msg_q;
    sh_d        = sh_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    frames_d    = frames_q;
    s_ready_d   = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
    case (state_q)
      ST_COLLECT: begin
        lat_d = '0;
        if (s_hs_c) begin
          for (int i = 0; i < MSG_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) msg_d[i*BYTE_W +: BYTE_W] = s.data;
          end
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            frame_err_d = ~s.last;
          end else if (s.last) begin
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (s_hs_c && s.last) idx_d = '0;
      end
      ST_WAIT: begin
        if (lat_done_c) begin
          m_data_d  = core_digest[DIG_W-1 -: BYTE_W];
          sh_d      = {core_digest[DIG_W-BYTE_W-1:0], BYTE_W'(0)};
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          bcnt_d    = '0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_SEND: begin
        if (m_hs_c) begin
          if (bcnt_q == LAST_BYTE) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            frames_d  = frames_q + CNT_W'(1);
            idx_d     = '0;
          end else begin
            m_data_d = sh_q[DIG_W-1 -: BYTE_W];
            sh_d     = {sh_q[DIG_W-BYTE_W-1:0], BYTE_W'(0)};
            bcnt_d   = bcnt_q + IDX_W'(1);
            m_last_d = (bcnt_q == PRE_LAST);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= '0;
      lat_q       <= '0;
      bcnt_q      <= '0;
      msg_q       <= '0;
      sh_q        <= '0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      s_ready_q   <= 1'b0;
      frame_err_q <= 1'b0;
      frames_q    <= '0;
    end else begin
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      bcnt_q      <= bcnt_d;
      msg_q       <= msg_d;
      sh_q        <= sh_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
      s_ready_q   <= s_ready_d;
      frame_err_q <= frame_err_d;
      frames_q    <= frames_d;
    end
  end

  assign s.ready     = s_ready_q;
  assign m.valid     = m_valid_q;
  assign m.data      = m_data_q;
  assign m.last      = m_last_q;
  assign core_msg    = msg_q;
  assign frame_err   = frame_err_q;
  assign frames_done = frames_q;

endmodule

// File: tb/tb_hash_byte_link.sv
// Randomized bench for hash_byte_link with a behavioural core model and frame-level reference.
module tb_hash_byte_link;

  localparam int unsigned CORE_LAT = 3;
  localparam int unsigned CNT_W    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hash_byte_link_if s_if ();
  hash_byte_link_if m_if ();

  logic [47:0]      core_msg;
  logic [63:0]      core_digest;
  logic             frame_err;
  logic [CNT_W-1:0] frames_done;

  // Stand-in hashing core: yields 0123456789ABCDEF for the message "ABCDEF"
  function automatic logic [63:0] core_fn(input logic [47:0] msg);
    return 64'h0123456789ABCDEF ^ {msg, msg[15:0]} ^ {48'h464544434241, 16'h4241};
  endfunction

  assign core_digest = core_fn(core_msg);

  hash_byte_link #(.CORE_LAT(CORE_LAT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (s_if),
    .m           (m_if),
    .core_msg    (core_msg),
    .core_digest (core_digest),
    .frame_err   (frame_err),
    .frames_done (frames_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [8:0] rx_q[$];
  int         err_pulses   = 0;
  int         valid_cycles = 0;
  int         rdy_mode     = 0;
  int         pat_i        = 0;
  int         exp_frames   = 0;
  logic       prev_stall   = 1'b0;
  logic [8:0] prev_byte    = '0;

  // Output-side monitor: records handshakes and checks hold-while-stalled
  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (m_if.valid) valid_cycles++;
    if (m_if.valid && prev_stall) begin
      check("stall_data", 64'(m_if.data), 64'(prev_byte[7:0]));
      check("stall_last", 64'(m_if.last), 64'(prev_byte[8]));
    end
    if (m_if.valid && m_if.ready) rx_q.push_back({m_if.last, m_if.data});
    prev_stall = m_if.valid && !m_if.ready;
    prev_byte  = {m_if.last, m_if.data};
  end

  // m_ready driver: 0 = always 1, 1 = pattern 1,0,0,1, 2 = random, other = held low
  initial begin
    m_if.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_if.ready = 1'b1;
        1: begin
          m_if.ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
          pat_i++;
        end
        2: m_if.ready = 1'($urandom_range(0, 1));
        default: m_if.ready = 1'b0;
      endcase
    end
  end

  // Push a byte sequence into the input stream; returns just after the last accepting edge
  task automatic send_bytes(input logic [7:0] b[$], input int last_pos, input bit gaps);
    int n;
    for (int i = 0; i < b.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      s_if.valid = 1'b1;
      s_if.data  = b[i];
      s_if.last  = (i == last_pos);
      n = 0;
      @(negedge clk);
      while (!s_if.ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        check("s_accept_timeout", 64'd0, 64'd1);
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      s_if.valid = 1'b0;
      s_if.last  = 1'b0;
    end
  endtask

  task automatic good_frame(input logic [47:0] msg, input bit gaps);
    logic [7:0]  b[$];
    logic [63:0] exp;
    int          lat;
    int          n;
    for (int i = 0; i < 6; i++) b.push_back(8'(msg >> (8 * i)));
    rx_q.delete();
    send_bytes(b, 5, gaps);
    check("s_ready_wait", 64'(s_if.ready), 64'd0);
    check("core_msg", 64'(core_msg), 64'(msg));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_if.valid && lat < 40);
    check("latency", 64'(lat), 64'(CORE_LAT + 1));
    n = 0;
    while (rx_q.size() < 8 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("digest_count", 64'(rx_q.size()), 64'd8);
    @(posedge clk);
    #1;
    exp_frames = (exp_frames + 1) % (1 << CNT_W);
    check("s_ready_after", 64'(s_if.ready), 64'd1);
    check("m_valid_after", 64'(m_if.valid), 64'd0);
    check("frames_done", 64'(frames_done), 64'(exp_frames));
    exp = core_fn(msg);
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      check("dig_byte", 64'(rx_q[i][7:0]), 64'(8'(exp >> (56 - 8 * i))));
      check("dig_last", 64'(rx_q[i][8]), 64'(i == 7));
    end
  endtask

  task automatic bad_frame(input logic [7:0] b[$], input int last_pos);
    int e0;
    int v0;
    e0 = err_pulses;
    v0 = valid_cycles;
    send_bytes(b, last_pos, 1'b0);
    repeat (CORE_LAT + 10) @(negedge clk);
    check("frame_err_pulses", 64'(err_pulses - e0), 64'd1);
    check("no_output", 64'(valid_cycles - v0), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int         n;
    rst_n      = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(s_if.ready), 64'd0);
    check("rst_m_valid", 64'(m_if.valid), 64'd0);
    check("rst_m_data", 64'(m_if.data), 64'd0);
    check("rst_m_last", 64'(m_if.last), 64'd0);
    check("rst_core_msg", 64'(core_msg), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_frames_done", 64'(frames_done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("s_ready_release", 64'(s_if.ready), 64'd1);

    // Basic frame "ABCDEF", then the same under 1,0,0,1 backpressure
    rdy_mode = 0;
    good_frame(48'h464544434241, 1'b0);
    rdy_mode = 1;
    good_frame(48'h464544434241, 1'b0);

    // Short frame then a good one
    rdy_mode = 0;
    q = '{8'h41, 8'h42, 8'h43};
    bad_frame(q, 2);
    good_frame(48'($urandom()) << 16 | 48'($urandom_range(0, 65535)), 1'b1);

    // Long frame (7 bytes) then a good one; counter wraps here
    q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    bad_frame(q, 6);
    good_frame(48'($urandom()) << 16 | 48'($urandom_range(0, 65535)), 1'b1);

    rdy_mode = 2;
    good_frame(48'($urandom()) << 16 | 48'($urandom_range(0, 65535)), 1'b1);

    // Reset in the middle of digest transmission
    rdy_mode = 0;
    rx_q.delete();
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom_range(0, 255)));
    send_bytes(q, 5, 1'b0);
    n = 0;
    while (rx_q.size() < 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    rdy_mode = 3;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_m_valid", 64'(m_if.valid), 64'd0);
    check("midrst_frames", 64'(frames_done), 64'd0);
    check("midrst_s_ready", 64'(s_if.ready), 64'd0);
    check("midrst_rx_count", 64'(rx_q.size()), 64'd3);
    rst_n      = 1'b1;
    rdy_mode   = 0;
    exp_frames = 0;
    @(posedge clk);
    #1;
    check("midrst_s_ready_rel", 64'(s_if.ready), 64'd1);
    good_frame(48'($urandom()) << 16 | 48'($urandom_range(0, 65535)), 1'b0);

    // Random frames under random backpressure modes
    for (int k = 0; k < 5; k++) begin
      rdy_mode = int'($urandom_range(0, 2));
      good_frame(48'($urandom()) << 16 | 48'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
